// File: rtl/mem_access_if.sv
// Bus bundle between the MEM stage/board side and the data-access controller.
interface mem_access_if #(
  parameter int ADDR_W = 14,
  parameter int LED_W  = 16
);
  logic              req_mread;
  logic              req_mwrite;
  logic              req_ioread;
  logic              req_iowrite;
  logic [1:0]        req_type;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [LED_W-1:0]  sw_in;
  logic [LED_W-1:0]  led_out;
  logic              err_misaligned;

  // Pipeline, RAM and board pins seen from outside the controller
  modport master (
    output req_mread, req_mwrite, req_ioread, req_iowrite,
    output req_type, req_addr, req_wdata, ram_rdata, sw_in,
    input  stall, rdata, rdata_valid, ram_addr, ram_we, ram_wdata,
    input  led_out, err_misaligned
  );

  // The controller itself
  modport slave (
    input  req_mread, req_mwrite, req_ioread, req_iowrite,
    input  req_type, req_addr, req_wdata, ram_rdata, sw_in,
    output stall, rdata, rdata_valid, ram_addr, ram_we, ram_wdata,
    output led_out, err_misaligned
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data access sequencer: RAM loads/stores (SB as read-modify-write),
// switch synchronizer, LED register and pipeline stall generation.
module mem_access_ctrl #(
  parameter int ADDR_W = 14,
  parameter int LED_W  = 16
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW} state_t;

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_lane;
  logic [1:0]        lat_type;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_hold;
  logic [LED_W-1:0]  sw_meta;
  logic [LED_W-1:0]  sw_sync;
  logic [LED_W-1:0]  led_q;

  logic              do_iowrite;
  logic              do_ioread;
  logic              do_mwrite;
  logic              do_mread;
  logic              aligned;
  logic              start_load;
  logic              start_rmw;
  logic [ADDR_W-1:0] idle_addr;
  logic [7:0]        ram_byte;
  logic [31:0]       rd_next;
  logic              rd_valid;
  logic              stall_c;
  logic              we_c;
  logic [31:0]       wdata_c;
  logic [ADDR_W-1:0] addr_c;
  logic              err_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  // Fixed-priority pick of the single request serviced this cycle
  always_comb begin
    do_iowrite = bus.req_iowrite;
    do_ioread  = !bus.req_iowrite && bus.req_ioread;
    do_mwrite  = !bus.req_iowrite && !bus.req_ioread && bus.req_mwrite;
    do_mread   = !bus.req_iowrite && !bus.req_ioread && !bus.req_mwrite && bus.req_mread;
    aligned    = (bus.req_addr[1:0] == 2'b00);
    idle_addr  = bus.req_addr[ADDR_W+1:2];
    start_load = (state == IDLE) && do_mread &&
                 ((bus.req_type == 2'b01) || (bus.req_type == 2'b10) || aligned);
    start_rmw  = (state == IDLE) && do_mwrite && (bus.req_type == 2'b01);
    ram_byte   = bus.ram_rdata[{lat_lane, 3'b000} +: 8];
  end

  // Per-state output decode; everything is forced quiet while reset is held
  always_comb begin
    rd_next  = 32'h0;
    rd_valid = 1'b0;
    stall_c  = 1'b0;
    we_c     = 1'b0;
    wdata_c  = 32'h0;
    addr_c   = idle_addr;
    err_c    = 1'b0;
    case (state)
      IDLE: begin
        if (do_ioread) begin
          rd_next  = {{(32-LED_W){1'b0}}, sw_sync};
          rd_valid = 1'b1;
        end else if (do_mwrite) begin
          if (bus.req_type == 2'b01) begin
            stall_c = 1'b1;
          end else if (aligned) begin
            we_c    = 1'b1;
            wdata_c = bus.req_wdata;
          end else begin
            err_c = 1'b1;
          end
        end else if (do_mread) begin
          if (start_load) begin
            stall_c = 1'b1;
          end else begin
            err_c    = 1'b1;
            rd_valid = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        addr_c   = lat_addr;
        rd_valid = 1'b1;
        case (lat_type)
          2'b01:   rd_next = {{24{ram_byte[7]}}, ram_byte};
          2'b10:   rd_next = {24'h0, ram_byte};
          default: rd_next = bus.ram_rdata;
        endcase
      end
      RMW: begin
        addr_c  = lat_addr;
        we_c    = 1'b1;
        wdata_c = bus.ram_rdata;
        wdata_c[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
      end
      default: begin
        addr_c = idle_addr;
      end
    endcase
    if (rst) begin
      rd_valid = 1'b0;
      stall_c  = 1'b0;
      we_c     = 1'b0;
      wdata_c  = 32'h0;
      err_c    = 1'b0;
    end
  end

  assign bus.stall          = stall_c;
  assign bus.rdata_valid    = rd_valid;
  assign bus.rdata          = rd_valid ? rd_next : rdata_hold;
  assign bus.ram_we         = we_c;
  assign bus.ram_wdata      = wdata_c;
  assign bus.ram_addr       = addr_c;
  assign bus.err_misaligned = err_c;
  assign bus.led_out        = led_q;

  // Access FSM: latch the request when a multi-cycle access starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_lane  <= 2'b00;
      lat_type  <= 2'b00;
      lat_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start_load || start_rmw) begin
            state     <= start_load ? LOAD_WAIT : RMW;
            lat_addr  <= idle_addr;
            lat_lane  <= bus.req_addr[1:0];
            lat_type  <= bus.req_type;
            lat_wdata <= bus.req_wdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Switch synchronizer, LED register and last-delivered load value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      led_q      <= '0;
      rdata_hold <= 32'h0;
    end else begin
      sw_meta <= bus.sw_in;
      sw_sync <= sw_meta;
      if (state == IDLE && do_iowrite)
        led_q <= bus.req_wdata[LED_W-1:0];
      if (rd_valid)
        rdata_hold <= rd_next;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl with a word-array reference model.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 14;
  localparam int LED_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_if #(.ADDR_W(ADDR_W), .LED_W(LED_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .LED_W(LED_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_rd [$];
  logic [45:0] exp_wr [$];
  logic [31:0] exp_err [$];
  logic [15:0] led_exp = 16'h0;
  logic [15:0] sw_now  = 16'h0;

  // Behavioural single-port RAM, read-first, one cycle read latency
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  // Monitor: pop and compare whenever the DUT presents a result or side effect
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rdata_valid) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("[TB] FAIL rdata_unexpected: got %h, required no rdata_valid", bus.rdata);
        end else begin
          logic [31:0] e;
          e = exp_rd.pop_front();
          if (bus.rdata !== e) begin
            errors++;
            $display("[TB] FAIL rdata: got %h, required %h", bus.rdata, e);
          end
        end
      end
      if (bus.ram_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("[TB] FAIL ram_write_unexpected: got addr %h data %h, required no write",
                   bus.ram_addr, bus.ram_wdata);
        end else begin
          logic [45:0] e;
          e = exp_wr.pop_front();
          if ({bus.ram_addr, bus.ram_wdata} !== e) begin
            errors++;
            $display("[TB] FAIL ram_write: got addr %h data %h, required addr %h data %h",
                     bus.ram_addr, bus.ram_wdata, e[45:32], e[31:0]);
          end
        end
      end
      if (bus.err_misaligned) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("[TB] FAIL err_unexpected: got pulse at addr %h, required none", bus.req_addr);
        end else begin
          logic [31:0] e;
          e = exp_err.pop_front();
          if (bus.req_addr !== e) begin
            errors++;
            $display("[TB] FAIL err_misaligned: got pulse at addr %h, required at %h", bus.req_addr, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic driveIdle();
    bus.req_mread   = 1'b0;
    bus.req_mwrite  = 1'b0;
    bus.req_ioread  = 1'b0;
    bus.req_iowrite = 1'b0;
    bus.req_type    = 2'b00;
    bus.req_addr    = 32'h0;
    bus.req_wdata   = 32'h0;
  endtask

  task automatic idleCycles(input int n);
    driveIdle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request (called at posedge+1), model it, hold it through any stall
  task automatic applyStimulus(input logic mr, input logic mw, input logic ir, input logic iw,
                               input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    int exp_stall;
    int stalls;
    int idx;
    int sh;
    logic [31:0] w;
    logic [7:0]  b;
    exp_stall = 0;
    idx = int'(a[15:2]);
    sh  = 8 * int'(a[1:0]);
    w   = ref_mem[idx];
    b   = 8'(w >> sh);
    if (iw) begin
      led_exp = d[15:0];
    end else if (ir) begin
      exp_rd.push_back({16'h0, sw_now});
    end else if (mw) begin
      if (t == 2'b01) begin
        w = (w & ~(32'hFF << sh)) | (32'(d[7:0]) << sh);
        ref_mem[idx] = w;
        exp_wr.push_back({a[15:2], w});
        exp_stall = 1;
      end else if (a[1:0] == 2'b00) begin
        ref_mem[idx] = d;
        exp_wr.push_back({a[15:2], d});
      end else begin
        exp_err.push_back(a);
      end
    end else if (mr) begin
      if (t == 2'b01) begin
        exp_rd.push_back(b[7] ? (32'hFFFFFF00 | 32'(b)) : 32'(b));
        exp_stall = 1;
      end else if (t == 2'b10) begin
        exp_rd.push_back(32'(b));
        exp_stall = 1;
      end else if (a[1:0] == 2'b00) begin
        exp_rd.push_back(w);
        exp_stall = 1;
      end else begin
        exp_rd.push_back(32'h0);
        exp_err.push_back(a);
      end
    end
    bus.req_mread   = mr;
    bus.req_mwrite  = mw;
    bus.req_ioread  = ir;
    bus.req_iowrite = iw;
    bus.req_type    = t;
    bus.req_addr    = a;
    bus.req_wdata   = d;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      else break;
    end
    @(posedge clk);
    #1;
    driveIdle();
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("led_out", 32'(bus.led_out), 32'(led_exp));
  endtask

  task automatic checkOutput();
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("err_queue_drained", 32'(exp_err.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) begin
      ram_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.sw_in = 16'h0;
    driveIdle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    check("reset_ram_we", 32'(bus.ram_we), 32'd0);
    check("reset_ram_wdata", bus.ram_wdata, 32'd0);
    check("reset_led_out", 32'(bus.led_out), 32'd0);
    check("reset_err", 32'(bus.err_misaligned), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Store then load back; byte loads with sign/zero extension
    applyStimulus(0, 1, 0, 0, 2'b00, 32'h10, 32'hDEADBEEF);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h10, 32'h0);
    applyStimulus(0, 1, 0, 0, 2'b00, 32'h10, 32'h12345680);
    applyStimulus(1, 0, 0, 0, 2'b01, 32'h13, 32'h0);
    applyStimulus(1, 0, 0, 0, 2'b01, 32'h10, 32'h0);
    applyStimulus(1, 0, 0, 0, 2'b10, 32'h10, 32'h0);
    // Byte store via read-modify-write
    applyStimulus(0, 1, 0, 0, 2'b00, 32'h10, 32'hAABBCCDD);
    applyStimulus(0, 1, 0, 0, 2'b01, 32'h12, 32'h11);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h10, 32'h0);
    // Switches, LEDs and priority between them
    bus.sw_in = 16'hA5A5;
    sw_now = 16'hA5A5;
    idleCycles(3);
    applyStimulus(0, 0, 1, 0, 2'b00, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 1, 2'b00, 32'h0, 32'h0001F00F);
    applyStimulus(0, 0, 1, 1, 2'b00, 32'h0, 32'h00001234);
    // Misaligned word accesses
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h11, 32'h0);
    applyStimulus(0, 1, 0, 0, 2'b00, 32'h22, 32'h55555555);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h20, 32'h0);

    // Reset while the SB write-back cycle is in flight
    bus.req_mwrite = 1'b1;
    bus.req_type   = 2'b01;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'h77;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_rmw_stall", 32'(bus.stall), 32'd0);
    check("rst_mid_rmw_we", 32'(bus.ram_we), 32'd0);
    driveIdle();
    @(negedge clk);
    rst = 1'b0;
    led_exp = 16'h0;
    check("rst_mid_rmw_led", 32'(bus.led_out), 32'd0);
    idleCycles(3);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h10, 32'h0);

    // Randomized mix of requests, including simultaneous flags and upper address bits
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  f;
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) begin
        sw_now = 16'($urandom);
        bus.sw_in = sw_now;
        idleCycles(3);
      end
      f = 4'($urandom);
      if (f == 4'h0) f = 4'h1;
      a = {16'($urandom), 10'h0, 4'($urandom), 2'($urandom)};
      applyStimulus(f[0], f[1], f[2] & ($urandom_range(0, 3) == 0), f[3] & ($urandom_range(0, 3) == 0),
                    2'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idleCycles(1);
    end

    idleCycles(3);
    checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
